// File: rtl/memory_access_stage.sv
// Pipeline M stage: latches execute results, runs one data-memory access per
// load/store over a req/gnt/rvalid bus, and aligns/extends returned load data.
module memory_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_to_m_valid,
  output logic        m_allow_in,
  output logic        m_to_w_valid,
  input  logic        w_allow_in,
  input  logic [31:0] E_valE,
  input  logic [31:0] E_val2,
  input  logic [6:0]  E_opcode,
  input  logic [2:0]  e_func3,
  input  logic [4:0]  E_rd,
  input  logic [31:0] E_pc,
  input  logic [31:0] E_instr,
  input  logic        E_commit,
  output logic        m_valid,
  output logic [31:0] M_valE,
  output logic [31:0] M_valM,
  output logic [4:0]  M_rd,
  output logic [6:0]  M_opcode,
  output logic [31:0] M_pc,
  output logic [31:0] M_instr,
  output logic        M_commit,
  output logic        M_misalign,
  output logic        M_bus_err,
  output logic        m_load_busy,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [6:0]        OP_LOAD  = 7'b0000011;
  localparam logic [6:0]        OP_STORE = 7'b0100011;
  localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit                TMO_EN   = (TIMEOUT != 32'd0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d, cap_state;
  logic              m_valid_q, m_valid_d;
  logic [31:0]       m_vale_q, m_vale_d, m_valm_q, m_valm_d;
  logic [4:0]        m_rd_q, m_rd_d;
  logic [6:0]        m_opcode_q, m_opcode_d;
  logic [31:0]       m_pc_q, m_pc_d, m_instr_q, m_instr_d;
  logic              m_commit_q, m_commit_d;
  logic [2:0]        m_func3_q, m_func3_d;
  logic              m_misalign_q, m_misalign_d, m_bus_err_q, m_bus_err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        e_is_load, e_is_store, e_is_mem, e_misalign, capture;
  logic        m_is_load, m_is_store, m_is_mem, m_ready_go, tmo_hit, tmo_fire;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign m_is_load  = (m_opcode_q == OP_LOAD);
  assign m_is_store = (m_opcode_q == OP_STORE);
  assign m_is_mem   = m_is_load | m_is_store;

  // Decode the incoming instruction and pick the state it enters on capture
  always_comb begin : e_decode
    e_is_load  = (E_opcode == OP_LOAD);
    e_is_store = (E_opcode == OP_STORE);
    e_is_mem   = e_is_load | e_is_store;
    e_misalign = e_is_mem & (((e_func3[1:0] == 2'b01) & E_valE[0]) |
                             (e_func3[1] & (E_valE[1:0] != 2'b00)));
    cap_state  = S_IDLE;
    if (e_is_mem) cap_state = e_misalign ? S_DONE : S_REQ;
  end

  // Store lane replication and byte enables, frozen at capture
  always_comb begin : st_lane
    st_wdata = E_val2;
    st_wstrb = 4'b1111;
    case (e_func3[1:0])
      2'b00: begin
        st_wdata = {4{E_val2[7:0]}};
        st_wstrb = 4'b0001 << E_valE[1:0];
      end
      2'b01: begin
        st_wdata = {2{E_val2[15:0]}};
        st_wstrb = 4'b0011 << {E_valE[1], 1'b0};
      end
      default: ;
    endcase
    if (!e_is_store) st_wstrb = 4'b0000;
  end

  always_comb begin : ld_align
    ld_byte = dmem_rdata[{m_vale_q[1:0], 3'b000} +: 8];
    ld_half = m_vale_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = dmem_rdata;
    case (m_func3_q[1:0])
      2'b00:   ld_data = m_func3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = m_func3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin : fsm_reg
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : fsm_out
    dmem_req     = (state_q == S_REQ);
    m_ready_go   = m_valid_q & (~m_is_mem | (state_q == S_DONE));
    m_allow_in   = ~m_valid_q | (m_ready_go & w_allow_in);
    m_to_w_valid = m_ready_go;
    m_load_busy  = m_valid_q & m_is_load & (state_q != S_DONE);
    capture      = m_allow_in & e_to_m_valid;
    tmo_hit      = TMO_EN & (cnt_q == CNT_LAST);
    tmo_fire     = tmo_hit & (((state_q == S_REQ) & ~dmem_gnt) |
                              ((state_q == S_WAIT) & ~dmem_rvalid));
  end

  // Handoff to writeback overrides the bus sequence; REQ/WAIT never accept
  always_comb begin : fsm_next
    state_d = state_q;
    if (m_allow_in) begin
      state_d = capture ? cap_state : S_IDLE;
    end else begin
      case (state_q)
        S_REQ: begin
          if (dmem_gnt)     state_d = m_is_store ? S_DONE : S_WAIT;
          else if (tmo_hit) state_d = S_DONE;
        end
        S_WAIT:  if (dmem_rvalid || tmo_hit) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin : dp_next
    m_valid_d    = m_valid_q;
    m_vale_d     = m_vale_q;
    m_valm_d     = m_valm_q;
    m_rd_d       = m_rd_q;
    m_opcode_d   = m_opcode_q;
    m_pc_d       = m_pc_q;
    m_instr_d    = m_instr_q;
    m_commit_d   = m_commit_q;
    m_func3_d    = m_func3_q;
    m_misalign_d = m_misalign_q;
    m_bus_err_d  = m_bus_err_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    if (m_allow_in) m_valid_d = e_to_m_valid;
    if (capture) begin
      m_vale_d     = E_valE;
      m_valm_d     = 32'd0;
      m_rd_d       = E_rd;
      m_opcode_d   = E_opcode;
      m_pc_d       = E_pc;
      m_instr_d    = E_instr;
      m_commit_d   = E_commit;
      m_func3_d    = e_func3;
      m_misalign_d = e_misalign;
      m_bus_err_d  = 1'b0;
      wdata_d      = st_wdata;
      wstrb_d      = st_wstrb;
    end
    if ((state_q == S_WAIT) && dmem_rvalid) m_valm_d = ld_data;
    if (tmo_fire) m_bus_err_d = 1'b1;
    if ((state_d == S_REQ) && (state_q != S_REQ))
      cnt_d = '0;
    else if ((state_q == S_REQ) || (state_q == S_WAIT))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin : dp_reg
    if (!rst) begin
      m_valid_q    <= 1'b0;
      m_vale_q     <= '0;
      m_valm_q     <= '0;
      m_rd_q       <= '0;
      m_opcode_q   <= '0;
      m_pc_q       <= '0;
      m_instr_q    <= '0;
      m_commit_q   <= 1'b0;
      m_func3_q    <= '0;
      m_misalign_q <= 1'b0;
      m_bus_err_q  <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
    end else begin
      m_valid_q    <= m_valid_d;
      m_vale_q     <= m_vale_d;
      m_valm_q     <= m_valm_d;
      m_rd_q       <= m_rd_d;
      m_opcode_q   <= m_opcode_d;
      m_pc_q       <= m_pc_d;
      m_instr_q    <= m_instr_d;
      m_commit_q   <= m_commit_d;
      m_func3_q    <= m_func3_d;
      m_misalign_q <= m_misalign_d;
      m_bus_err_q  <= m_bus_err_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign M_valE     = m_vale_q;
  assign M_valM     = m_valm_q;
  assign M_rd       = m_rd_q;
  assign M_opcode   = m_opcode_q;
  assign M_pc       = m_pc_q;
  assign M_instr    = m_instr_q;
  assign M_commit   = m_commit_q;
  assign M_misalign = m_misalign_q;
  assign M_bus_err  = m_bus_err_q;
  assign dmem_we    = m_is_store;
  assign dmem_addr  = {m_vale_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: table of single accesses plus
// hand-written sequences for bus stalls, timeouts, backpressure and reset.
module tb_memory_access_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        e_to_m_valid, m_allow_in, m_to_w_valid, w_allow_in;
  logic [31:0] E_valE, E_val2, E_pc, E_instr;
  logic [6:0]  E_opcode;
  logic [2:0]  e_func3;
  logic [4:0]  E_rd;
  logic        E_commit;
  logic        m_valid;
  logic [31:0] M_valE, M_valM, M_pc, M_instr;
  logic [4:0]  M_rd;
  logic [6:0]  M_opcode;
  logic        M_commit, M_misalign, M_bus_err, m_load_busy;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
    .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
    .E_valE(E_valE), .E_val2(E_val2), .E_opcode(E_opcode), .e_func3(e_func3),
    .E_rd(E_rd), .E_pc(E_pc), .E_instr(E_instr), .E_commit(E_commit),
    .m_valid(m_valid), .M_valE(M_valE), .M_valM(M_valM), .M_rd(M_rd),
    .M_opcode(M_opcode), .M_pc(M_pc), .M_instr(M_instr), .M_commit(M_commit),
    .M_misalign(M_misalign), .M_bus_err(M_bus_err), .m_load_busy(m_load_busy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] vale;
    logic [31:0] val2;
    logic [31:0] rdata;
    logic        exp_req;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_valm;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] vale, input logic [31:0] val2, input int tag);
    e_to_m_valid = 1'b1;
    E_opcode = op;
    e_func3  = f3;
    E_valE   = vale;
    E_val2   = val2;
    E_rd     = 5'(tag + 1);
    E_pc     = 32'h1000 + 32'(tag * 4);
    E_instr  = 32'hA000_0000 + 32'(tag);
    E_commit = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,   3'b000, 32'h1234_5678, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[1]  = '{OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{OP_STORE, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,         1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{OP_STORE, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0,         1'b1, 4'hC, 32'hBEEF_BEEF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_0077, 32'h0,         1'b1, 4'h8, 32'h7777_7777, 32'h0000_0000, 1'b0};
    vecs[5]  = '{OP_LOAD,  3'b000, 32'h0000_0103, 32'h0,         32'h8011_2233, 1'b1, 4'h0, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[6]  = '{OP_LOAD,  3'b100, 32'h0000_0103, 32'h0,         32'h8011_2233, 1'b1, 4'h0, 32'h0,         32'h0000_0080, 1'b0};
    vecs[7]  = '{OP_LOAD,  3'b101, 32'h0000_0102, 32'h0,         32'h8011_2233, 1'b1, 4'h0, 32'h0,         32'h0000_8011, 1'b0};
    vecs[8]  = '{OP_LOAD,  3'b001, 32'h0000_0102, 32'h0,         32'h8011_2233, 1'b1, 4'h0, 32'h0,         32'hFFFF_8011, 1'b0};
    vecs[9]  = '{OP_LOAD,  3'b001, 32'h0000_0100, 32'h0,         32'h8011_7FFF, 1'b1, 4'h0, 32'h0,         32'h0000_7FFF, 1'b0};
    vecs[10] = '{OP_LOAD,  3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1'b1, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[11] = '{OP_LOAD,  3'b000, 32'h0000_0101, 32'h0,         32'h0000_FE00, 1'b1, 4'h0, 32'h0,         32'hFFFF_FFFE, 1'b0};
    vecs[12] = '{OP_LOAD,  3'b000, 32'h0000_0100, 32'h0,         32'h0000_007F, 1'b1, 4'h0, 32'h0,         32'h0000_007F, 1'b0};
    vecs[13] = '{OP_LOAD,  3'b010, 32'h0000_0102, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[14] = '{OP_STORE, 3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0,         1'b0, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{OP_LOAD,  3'b101, 32'h0000_0103, 32'h0,         32'h0,         1'b0, 4'h0, 32'h0,         32'h0000_0000, 1'b1};

    rst = 1'b0; e_to_m_valid = 1'b0; w_allow_in = 1'b1;
    E_valE = '0; E_val2 = '0; E_opcode = '0; e_func3 = '0; E_rd = '0;
    E_pc = '0; E_instr = '0; E_commit = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    // Reset state
    repeat (2) step();
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_valE", M_valE, 32'd0);
    chk("rst_valM", M_valM, 32'd0);
    chk("rst_allow_in", 32'(m_allow_in), 32'd1);
    chk("rst_to_w", 32'(m_to_w_valid), 32'd0);
    rst = 1'b1;

    // Table of single, uncontended accesses
    for (int i = 0; i < NV; i++) begin
      step();
      present(vecs[i].op, vecs[i].f3, vecs[i].vale, vecs[i].val2, i);
      #1 chk($sformatf("v%0d_allow_in", i), 32'(m_allow_in), 32'd1);
      step();
      e_to_m_valid = 1'b0;
      #1;
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].vale & ~32'h3);
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].op == OP_STORE));
        chk($sformatf("v%0d_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].exp_wstrb));
        if (vecs[i].op == OP_STORE)
          chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        if (vecs[i].op == OP_LOAD) begin
          #1 chk($sformatf("v%0d_busy", i), 32'(m_load_busy), 32'd1);
          dmem_rvalid = 1'b1;
          dmem_rdata  = vecs[i].rdata;
          step();
          dmem_rvalid = 1'b0;
          dmem_rdata  = '0;
        end
      end else begin
        chk($sformatf("v%0d_noreq", i), 32'(dmem_req), 32'd0);
      end
      #1;
      chk($sformatf("v%0d_to_w", i), 32'(m_to_w_valid), 32'd1);
      chk($sformatf("v%0d_valM", i), M_valM, vecs[i].exp_valm);
      chk($sformatf("v%0d_misalign", i), 32'(M_misalign), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_valE", i), M_valE, vecs[i].vale);
      chk($sformatf("v%0d_rd", i), 32'(M_rd), 32'(i + 1));
      chk($sformatf("v%0d_pc", i), M_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_bus_err", i), 32'(M_bus_err), 32'd0);
      step();
      #1 chk($sformatf("v%0d_drained", i), 32'(m_valid), 32'd0);
    end

    // SW with grant in the third request cycle; E inputs change underneath
    step();
    present(OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 20);
    step();
    present(OP_ADD, 3'b000, 32'hFFFF_FFF0, 32'h5555_5555, 21);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sw_req%0d", k), 32'(dmem_req), 32'd1);
      chk($sformatf("sw_addr%0d", k), dmem_addr, 32'h0000_0100);
      chk($sformatf("sw_wdata%0d", k), dmem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("sw_wstrb%0d", k), 32'(dmem_wstrb), 32'hF);
      chk($sformatf("sw_allow%0d", k), 32'(m_allow_in), 32'd0);
      if (k == 2) dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
    end
    #1;
    chk("sw_req_drop", 32'(dmem_req), 32'd0);
    chk("sw_to_w", 32'(m_to_w_valid), 32'd1);
    chk("sw_valE", M_valE, 32'h0000_0100);
    chk("sw_allow_b2b", 32'(m_allow_in), 32'd1);
    step();
    e_to_m_valid = 1'b0;
    #1;
    chk("add_b2b_valE", M_valE, 32'hFFFF_FFF0);
    chk("add_b2b_to_w", 32'(m_to_w_valid), 32'd1);
    chk("add_b2b_noreq", 32'(dmem_req), 32'd0);
    step();
    #1 chk("add_b2b_drained", 32'(m_valid), 32'd0);

    // Timeout in REQ: no grant ever
    step();
    present(OP_LOAD, 3'b010, 32'h0000_0200, 32'h0, 30);
    step();
    e_to_m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("tmo_req%0d", k), 32'(dmem_req), 32'd1);
      step();
    end
    #1;
    chk("tmo_req_drop", 32'(dmem_req), 32'd0);
    chk("tmo_bus_err", 32'(M_bus_err), 32'd1);
    chk("tmo_to_w", 32'(m_to_w_valid), 32'd1);
    chk("tmo_valM", M_valM, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    #1;
    chk("tmo_drained", 32'(m_valid), 32'd0);
    chk("tmo_late_rvalid", M_valM, 32'd0);

    // Timeout in WAIT: granted, data never returns
    step();
    present(OP_LOAD, 3'b001, 32'h0000_0202, 32'h0, 31);
    step();
    e_to_m_valid = 1'b0;
    #1 chk("wtmo_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wtmo_busy%0d", k), 32'(m_load_busy), 32'd1);
      chk($sformatf("wtmo_noreq%0d", k), 32'(dmem_req), 32'd0);
      step();
    end
    #1;
    chk("wtmo_bus_err", 32'(M_bus_err), 32'd1);
    chk("wtmo_busy_done", 32'(m_load_busy), 32'd0);
    chk("wtmo_to_w", 32'(m_to_w_valid), 32'd1);
    step();
    #1 chk("wtmo_drained", 32'(m_valid), 32'd0);

    // Writeback backpressure in DONE, then back-to-back load capture
    w_allow_in = 1'b0;
    step();
    present(OP_LOAD, 3'b010, 32'h0000_0300, 32'h0, 40);
    step();
    present(OP_LOAD, 3'b100, 32'h0000_0301, 32'h0, 41);
    #1;
    chk("bp_req", 32'(dmem_req), 32'd1);
    chk("bp_allow_req", 32'(m_allow_in), 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1122_3344;
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_allow%0d", k), 32'(m_allow_in), 32'd0);
      chk($sformatf("bp_to_w%0d", k), 32'(m_to_w_valid), 32'd1);
      chk($sformatf("bp_valM%0d", k), M_valM, 32'h1122_3344);
      chk($sformatf("bp_valE%0d", k), M_valE, 32'h0000_0300);
      step();
    end
    w_allow_in = 1'b1;
    #1 chk("bp_release", 32'(m_allow_in), 32'd1);
    step();
    e_to_m_valid = 1'b0;
    #1;
    chk("b2b_valid", 32'(m_valid), 32'd1);
    chk("b2b_valE", M_valE, 32'h0000_0301);
    chk("b2b_req", 32'(dmem_req), 32'd1);
    chk("b2b_valM_clr", M_valM, 32'd0);
    chk("b2b_busy", 32'(m_load_busy), 32'd1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_AB00;
    step();
    dmem_rvalid = 1'b0;
    #1;
    chk("b2b_valM", M_valM, 32'h0000_00AB);
    chk("b2b_to_w", 32'(m_to_w_valid), 32'd1);
    step();
    #1 chk("b2b_drained", 32'(m_valid), 32'd0);

    // Reset in the middle of a request
    step();
    present(OP_LOAD, 3'b010, 32'h0000_0400, 32'h0, 50);
    step();
    e_to_m_valid = 1'b0;
    #1 chk("mid_req", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    step();
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    #1;
    chk("mid_ignored_valid", 32'(m_valid), 32'd0);
    chk("mid_ignored_valM", M_valM, 32'd0);
    chk("mid_ignored_valE", M_valE, 32'd0);
    chk("mid_ignored_to_w", 32'(m_to_w_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
